rpn_sequencer: RTL

RPN_SEQUENCER -- requirements
Module: rpn_sequencer

---
 rtl/rpn_pkg.sv | 19 +
 rtl/rpn_pulse_generator.sv | 18 +
 rtl/rpn_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/rpn_pkg.sv
// Shared types and constants for the RPN calculator sequencer.
package rpn_pkg;

   localparam int DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXEC  = 2'd1,
      ERROR = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_XOR = 2'b11
   } op_t;

endpackage

// File: rtl/rpn_pulse_generator.sv
// Rising-edge detector: one-clock pulse per button press.
module pulse_generator (
   input  logic clk,
   input  logic rst,
   input  logic _in,
   output logic _out
);

   logic prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev <= 1'b0;
      else     prev <= _in;
   end

   assign _out = _in & ~prev;

endmodule

// File: rtl/rpn_sequencer.sv
// Four-entry RPN stack calculator driven by push/execute/clear buttons.
module rpn_sequencer
   import rpn_pkg::*;
#(
   parameter int DEPTH = rpn_pkg::DEPTH
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] sw,
   input  logic [2:0] btn,
   output logic [3:0] ld,
   output logic [2:0] depth,
   output logic       err
);

   localparam logic [2:0] DMAX = 3'(DEPTH);

   logic [2:0] pls;
   state_t     state, state_n;
   op_t        op;
   logic [3:0] stk [DEPTH];
   logic [2:0] cnt;
   logic [3:0] res;
   logic       do_clr, do_push, do_exec, op_ld;

   for (genvar g = 0; g < 3; g++) begin : g_pg
      pulse_generator u_pg (
         .clk  (clk),
         .rst  (rst),
         ._in  (btn[g]),
         ._out (pls[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Clear wins over everything; execute beats push.
   always_comb begin
      state_n = state;
      do_clr  = 1'b0;
      do_push = 1'b0;
      do_exec = 1'b0;
      op_ld   = 1'b0;
      if (pls[2]) begin
         do_clr  = 1'b1;
         state_n = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (pls[1]) begin
                  if (cnt >= 3'd2) begin
                     op_ld   = 1'b1;
                     state_n = EXEC;
                  end else begin
                     state_n = ERROR;
                  end
               end else if (pls[0]) begin
                  if (cnt < DMAX) do_push = 1'b1;
                  else            state_n = ERROR;
               end
            end
            EXEC: begin
               do_exec = 1'b1;
               state_n = IDLE;
            end
            ERROR: ;
            default: state_n = IDLE;
         endcase
      end
   end

   always_comb begin
      res = '0;
      unique case (op)
         OP_ADD: res = stk[1] + stk[0];
         OP_SUB: res = stk[1] - stk[0];
         OP_AND: res = stk[1] & stk[0];
         OP_XOR: res = stk[1] ^ stk[0];
      endcase
   end

   // stk[0] is the top; vacated slots are zero-filled so ld reads 0 when empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
         cnt <= '0;
         op  <= OP_ADD;
         err <= 1'b0;
      end else begin
         err <= (state_n == ERROR);
         if (do_clr) begin
            for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
            cnt <= '0;
         end else if (do_push) begin
            stk[0] <= sw;
            for (int i = 1; i < DEPTH; i++) stk[i] <= stk[i-1];
            cnt <= cnt + 3'd1;
         end else if (do_exec) begin
            stk[0] <= res;
            for (int i = 1; i < DEPTH - 1; i++) stk[i] <= stk[i+1];
            stk[DEPTH-1] <= '0;
            cnt <= cnt - 3'd1;
         end
         if (op_ld) op <= op_t'(sw[1:0]);
      end
   end

   assign ld    = stk[0];
   assign depth = cnt;

endmodule
